// File: rtl/booth4_mult_param.sv
// Radix-4 (modified Booth) signed multiplier with start/abort handshake, WIDTH/2 iterations.
// Defining MULT_HI_RESULT_EN adds the registered upper product half on data_result_hi.
module booth4_mult_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
`ifdef MULT_HI_RESULT_EN
  ,
  output logic [WIDTH-1:0] data_result_hi
`endif
);

  localparam int AW = WIDTH + 2;        // accumulator width, holds +/-2A without overflow
  localparam int PW = 2 * WIDTH + 3;    // {accumulator, multiplier, booth guard bit}
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH / 2 - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    p_q, p_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             exc_q, exc_d;
`ifdef MULT_HI_RESULT_EN
  logic [WIDTH-1:0] hi_q, hi_d;
`endif

  logic [AW-1:0]      a_ext;
  logic [AW-1:0]      addend;
  logic [AW-1:0]      acc_sum;
  logic [PW-1:0]      p_add;
  logic [PW-1:0]      p_shift;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     prod_upper;

  // Booth recoding of the triplet P[2:0] into one of 0, +A, +2A, -2A, -A.
  always_comb begin
    a_ext = {{2{a_q[WIDTH-1]}}, a_q};
    unique case (p_q[2:0])
      3'b001, 3'b010: addend = a_ext;
      3'b011:         addend = a_ext << 1;
      3'b100:         addend = ~(a_ext << 1) + AW'(1);
      3'b101, 3'b110: addend = ~a_ext + AW'(1);
      default:        addend = '0;
    endcase
    acc_sum    = p_q[PW-1:WIDTH+1] + addend;
    p_add      = {acc_sum, p_q[WIDTH:0]};
    p_shift    = {{2{p_add[PW-1]}}, p_add[PW-1:2]};
    prod       = p_shift[2*WIDTH:1];
    prod_upper = prod[2*WIDTH-1:WIDTH-1];
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d = state_q;
    p_d     = p_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    exc_d   = exc_q;
`ifdef MULT_HI_RESULT_EN
    hi_d    = hi_q;
`endif
    if (ctrl_MULT) begin
      // A start in any state (re)loads both operands; an in-flight run is abandoned.
      state_d = RUN;
      a_d     = data_operandA;
      p_d     = {AW'(0), data_operandB, 1'b0};
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          p_d   = p_shift;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) begin
            state_d = DONE;
            res_d   = prod[WIDTH-1:0];
            exc_d   = ~((&prod_upper) | (~|prod_upper));
`ifdef MULT_HI_RESULT_EN
            hi_d    = prod[2*WIDTH-1:WIDTH];
`endif
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q <= IDLE;
      p_q     <= '0;
      a_q     <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
      exc_q   <= 1'b0;
`ifdef MULT_HI_RESULT_EN
      hi_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      p_q     <= p_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      exc_q   <= exc_d;
`ifdef MULT_HI_RESULT_EN
      hi_q    <= hi_d;
`endif
    end
  end

  assign data_result    = res_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == DONE);
  assign busy           = (state_q == RUN);
`ifdef MULT_HI_RESULT_EN
  assign data_result_hi = hi_q;
`endif

endmodule

// File: tb/tb_booth4_mult_param.sv
// Scoreboard bench for booth4_mult_param (WIDTH=32): latency, arithmetic, abort, restart, reset.
// Expected products come from a 64-bit signed multiply model; hi half checked when MULT_HI_RESULT_EN is set.
module tb_booth4_mult_param;

  localparam int W = 32;
  localparam int N = W / 2;

  typedef struct packed {
    logic [W-1:0] res;
    logic         exc;
    logic [W-1:0] hi;
  } exp_t;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] op_a, op_b;
  logic         ctrl;
  logic [W-1:0] data_result;
  logic         data_exception, data_resultRDY, busy;
`ifdef MULT_HI_RESULT_EN
  logic [W-1:0] data_result_hi;
`endif

  exp_t sb[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  booth4_mult_param #(.WIDTH(W), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .ctrl_MULT      (ctrl),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
`ifdef MULT_HI_RESULT_EN
    ,
    .data_result_hi (data_result_hi)
`endif
  );

  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] p;
    exp_t e;
    p     = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
    e.res = p[W-1:0];
    e.hi  = p[2*W-1:W];
    e.exc = (p != {{W{p[W-1]}}, p[W-1:0]});
    return e;
  endfunction

  // Called at a falling edge; the start is sampled at the next rising edge and
  // the task returns at the falling edge of cycle 1 with operands scrambled.
  task automatic pulse_start(input logic [W-1:0] a, input logic [W-1:0] b);
    ctrl = 1'b1;
    op_a = a;
    op_b = b;
    sb.push_back(model(a, b));
    @(negedge clock);
    ctrl = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
  endtask

  // Starts at cycle 1; returns at the falling edge where RDY is seen (cyc) or -1.
  task automatic wait_rdy(output int cyc, output int busy_err);
    cyc      = -1;
    busy_err = 0;
    for (int c = 1; c <= 40; c++) begin
      if (data_resultRDY === 1'b1) begin
        cyc = c;
        if (busy !== 1'b0) busy_err++;
        return;
      end
      if (busy !== (c <= N)) busy_err++;
      @(negedge clock);
    end
  endtask

  task automatic pop_exp(output exp_t e);
    e = '0;
    if (sb.size() != 0) e = sb.pop_front();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ctrl  = 1'b1;
    op_a  = 32'd7;
    op_b  = 32'd3;
    repeat (3) @(negedge clock);
    total_cnt++;
    if (data_result !== '0) $display("FAIL reset_result: got %h want 0", data_result);
    else pass_cnt++;
    total_cnt++;
    if ({data_exception, data_resultRDY, busy} !== 3'b000)
      $display("FAIL reset_flags: got exc/rdy/busy %b want 000", {data_exception, data_resultRDY, busy});
    else pass_cnt++;
`ifdef MULT_HI_RESULT_EN
    total_cnt++;
    if (data_result_hi !== '0) $display("FAIL reset_hi: got %h want 0", data_result_hi);
    else pass_cnt++;
`endif
    reset = 1'b0;
    ctrl  = 1'b0;
    @(negedge clock);
    total_cnt++;
    if ({data_resultRDY, busy} !== 2'b00)
      $display("FAIL reset_priority: got rdy/busy %b want 00", {data_resultRDY, busy});
    else pass_cnt++;
  endtask

  task automatic test_multiply();
    logic [W-1:0] va[12];
    logic [W-1:0] vb[12];
    exp_t e;
    int   cyc, berr;
    va = '{32'd7, 32'h7FFFFFFF, 32'h80000000, 32'h80000000, 32'h7FFFFFFF, 32'd0,
           32'hFFFFFFFF, 32'h00010000, 32'h0, 32'h0, 32'h0, 32'h0};
    vb = '{32'hFFFFFFFD, 32'd2, 32'hFFFFFFFF, 32'd1, 32'h7FFFFFFF, 32'h12345678,
           32'hFFFFFFFF, 32'h00010000, 32'h0, 32'h0, 32'h0, 32'h0};
    va[8]  = 32'h80000000;  vb[8]  = 32'h80000000;
    va[9]  = $urandom;      vb[9]  = $urandom;
    va[10] = $urandom_range(0, 4000) - 2000;
    vb[10] = $urandom_range(0, 4000) - 2000;
    va[11] = $urandom;      vb[11] = $urandom_range(0, 30) - 15;
    for (int i = 0; i < 12; i++) begin
      pulse_start(va[i], vb[i]);
      wait_rdy(cyc, berr);
      pop_exp(e);
      total_cnt++;
      if (cyc !== N + 1) $display("FAIL mul%0d_latency: got %0d want %0d", i, cyc, N + 1);
      else pass_cnt++;
      total_cnt++;
      if (berr !== 0) $display("FAIL mul%0d_busy: got %0d busy errors want 0", i, berr);
      else pass_cnt++;
      total_cnt++;
      if (data_result !== e.res)
        $display("FAIL mul%0d_result %h*%h: got %h want %h", i, va[i], vb[i], data_result, e.res);
      else pass_cnt++;
      total_cnt++;
      if (data_exception !== e.exc)
        $display("FAIL mul%0d_exc %h*%h: got %b want %b", i, va[i], vb[i], data_exception, e.exc);
      else pass_cnt++;
`ifdef MULT_HI_RESULT_EN
      total_cnt++;
      if (data_result_hi !== e.hi)
        $display("FAIL mul%0d_hi %h*%h: got %h want %h", i, va[i], vb[i], data_result_hi, e.hi);
      else pass_cnt++;
`endif
      @(negedge clock);
      total_cnt++;
      if ({data_resultRDY, data_result} !== {1'b0, e.res})
        $display("FAIL mul%0d_hold: got rdy %b res %h want rdy 0 res %h", i, data_resultRDY, data_result, e.res);
      else pass_cnt++;
    end
  endtask

  task automatic test_abort();
    exp_t e;
    int   cyc, berr, early;
    early = 0;
    pulse_start(32'd5, 32'd5);
    for (int c = 1; c < 8; c++) begin
      if (data_resultRDY !== 1'b0) early++;
      @(negedge clock);
    end
    void'(sb.pop_back());
    pulse_start(32'd3, 32'd4);
    wait_rdy(cyc, berr);
    pop_exp(e);
    total_cnt++;
    if (early !== 0 || cyc !== N + 1)
      $display("FAIL abort_latency: got early %0d cyc %0d want 0 and %0d", early, cyc, N + 1);
    else pass_cnt++;
    total_cnt++;
    if ({data_exception, data_result} !== {e.exc, e.res})
      $display("FAIL abort_result: got %b/%h want %b/%h", data_exception, data_result, e.exc, e.res);
    else pass_cnt++;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   cyc, berr;
    logic [W-1:0] old_res;
    pulse_start(32'hFFFFFFFA, 32'd9);
    wait_rdy(cyc, berr);
    pop_exp(e);
    total_cnt++;
    if (data_result !== e.res) $display("FAIL b2b_first: got %h want %h", data_result, e.res);
    else pass_cnt++;
    old_res = e.res;
    pulse_start(32'h00001234, 32'hFFFFFFFE);
    total_cnt++;
    if ({data_resultRDY, busy, data_result} !== {2'b01, old_res})
      $display("FAIL b2b_restart: got rdy/busy %b%b res %h want 01 %h", data_resultRDY, busy, data_result, old_res);
    else pass_cnt++;
    wait_rdy(cyc, berr);
    pop_exp(e);
    total_cnt++;
    if (cyc !== N + 1 || berr !== 0)
      $display("FAIL b2b_latency: got cyc %0d busy errs %0d want %0d and 0", cyc, berr, N + 1);
    else pass_cnt++;
    total_cnt++;
    if (data_result !== e.res) $display("FAIL b2b_second: got %h want %h", data_result, e.res);
    else pass_cnt++;
    @(negedge clock);
  endtask

  task automatic test_held_start();
    exp_t e;
    int   cyc, berr;
    ctrl = 1'b1;
    op_a = 32'd11;
    op_b = 32'd13;
    @(negedge clock);
    op_a = 32'd21;
    op_b = 32'd23;
    @(negedge clock);
    op_a = 32'hFFFFFF00;
    op_b = 32'h00000100;
    sb.push_back(model(op_a, op_b));
    @(negedge clock);
    ctrl = 1'b0;
    op_a = $urandom;
    op_b = $urandom;
    wait_rdy(cyc, berr);
    pop_exp(e);
    total_cnt++;
    if (cyc !== N + 1) $display("FAIL held_latency: got %0d want %0d", cyc, N + 1);
    else pass_cnt++;
    total_cnt++;
    if ({data_exception, data_result} !== {e.exc, e.res})
      $display("FAIL held_result: got %b/%h want %b/%h", data_exception, data_result, e.exc, e.res);
    else pass_cnt++;
    @(negedge clock);
  endtask

  task automatic test_reset_mid();
    int rdy_seen;
    rdy_seen = 0;
    pulse_start(32'd5, 32'd5);
    repeat (5) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    total_cnt++;
    if ({data_result, data_exception, data_resultRDY, busy} !== '0)
      $display("FAIL midreset_outputs: got res %h exc/rdy/busy %b%b%b want all 0",
               data_result, data_exception, data_resultRDY, busy);
    else pass_cnt++;
    reset = 1'b0;
    void'(sb.pop_back());
    for (int c = 0; c < 40; c++) begin
      @(negedge clock);
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) rdy_seen++;
    end
    total_cnt++;
    if (rdy_seen !== 0) $display("FAIL midreset_no_rdy: got %0d active cycles want 0", rdy_seen);
    else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    ctrl  = 1'b0;
    op_a  = '0;
    op_b  = '0;
    test_reset();
    test_multiply();
    test_abort();
    test_back_to_back();
    test_held_start();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
